// File: rtl/io_ctrl_pkg.sv
// io_ctrl_pkg: shared types and helpers for the pulse-sequencer IO controller.
//   chan_state_e : per-channel FSM state
//   DW_DEF/CW_DEF: default counter / pulse-count widths
//   lsb()        : low bit index of lane c in a flattened bus of w-bit lanes
package io_ctrl_pkg;

    localparam int DW_DEF = 16;
    localparam int CW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        ACTIVE,
        GAP,
        DONE
    } chan_state_e;

    function automatic int lsb(input int c, input int w);
        return c * w;
    endfunction

endpackage

// File: rtl/io_pulse_chan.sv
// io_pulse_chan: one programmable pulse-train channel (delay, N pulses of W cycles, G-cycle gaps).
//   clk, rst     : clock, synchronous active-low reset
//   rest_i       : live idle level of the output
//   arm_i, go_i  : config latch strobe, trigger
//   stop_i       : level-sensitive abort, behaves like reset
//   delay_i, width_i, gap_i, count_i : config, sampled only when arm is accepted
//   out_o, busy_o, done_o            : registered output level, running flag, sticky done
module io_pulse_chan
    import io_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rest_i,
    input  logic          arm_i,
    input  logic          go_i,
    input  logic          stop_i,
    input  logic [DW-1:0] delay_i,
    input  logic [DW-1:0] width_i,
    input  logic [DW-1:0] gap_i,
    input  logic [CW-1:0] count_i,
    output logic          out_o,
    output logic          busy_o,
    output logic          done_o
);

    chan_state_e   state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [DW-1:0] d_q, w_q, g_q;
    logic [CW-1:0] n_q;
    logic          out_q, busy_q, done_q;
    logic          latch, fire;

    // cnt holds "cycles left minus one" in the current phase; pcnt holds pulses left
    always_comb begin
        latch   = arm_i && (state_q == IDLE || state_q == ARMED || state_q == DONE);
        fire    = go_i && (state_q == ARMED || (state_q == IDLE && arm_i));
        state_d = state_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            IDLE, ARMED, DONE: begin
                if (latch) state_d = ARMED;
                // a same-cycle arm takes the fresh config straight from the inputs
                if (fire) begin
                    state_d = DELAY;
                    cnt_d   = latch ? delay_i : d_q;
                    pcnt_d  = latch ? count_i : n_q;
                end
            end
            DELAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (w_q == '0 || pcnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = ACTIVE;
                    cnt_d   = w_q - 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (pcnt_q > CW'(1)) begin
                    pcnt_d  = pcnt_q - 1'b1;
                    // zero gap: next pulse starts immediately, merging with this one
                    state_d = (g_q == '0) ? ACTIVE : GAP;
                    cnt_d   = (g_q == '0) ? w_q - 1'b1 : g_q - 1'b1;
                end else begin
                    state_d = DONE;
                    pcnt_d  = '0;
                end
            end
            GAP: begin
                state_d = (cnt_q == '0) ? ACTIVE : GAP;
                cnt_d   = (cnt_q == '0) ? w_q - 1'b1 : cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || stop_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            d_q     <= '0;
            w_q     <= '0;
            g_q     <= '0;
            n_q     <= '0;
            out_q   <= rest_i;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            if (latch) begin
                d_q <= delay_i;
                w_q <= width_i;
                g_q <= gap_i;
                n_q <= count_i;
            end
            out_q  <= (state_d == ACTIVE) ? ~rest_i : rest_i;
            busy_q <= state_d inside {DELAY, ACTIVE, GAP};
            done_q <= state_d == DONE;
        end
    end

    assign out_o  = out_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/io_pulse_seq_ctrl.sv
// io_pulse_seq_ctrl: NCH independent pulse-train output channels fired by a shared trigger.
//   clk, rst                  : clock, synchronous active-low reset
//   rest_level[NCH]           : live idle level per channel
//   arm[NCH], go, hard_stop   : per-channel config latch, shared trigger, global abort
//   cfg_delay/width/gap/count : flattened per-channel config, lane c at [c*W +: W]
//   out_state, busy, complete : per-channel output, running flag, sticky done
//   all_complete              : every channel armed since the last clear is done
module io_pulse_seq_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = DW_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    rest_level,
    input  logic [NCH-1:0]    arm,
    input  logic              go,
    input  logic              hard_stop,
    input  logic [NCH*DW-1:0] cfg_delay,
    input  logic [NCH*DW-1:0] cfg_width,
    input  logic [NCH*DW-1:0] cfg_gap,
    input  logic [NCH*CW-1:0] cfg_count,
    output logic [NCH-1:0]    out_state,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    complete,
    output logic              all_complete
);

    logic [NCH-1:0] mask_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        io_pulse_chan #(.DW(DW), .CW(CW)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .rest_i  (rest_level[c]),
            .arm_i   (arm[c]),
            .go_i    (go),
            .stop_i  (hard_stop),
            .delay_i (cfg_delay[lsb(c, DW) +: DW]),
            .width_i (cfg_width[lsb(c, DW) +: DW]),
            .gap_i   (cfg_gap[lsb(c, DW) +: DW]),
            .count_i (cfg_count[lsb(c, CW) +: CW]),
            .out_o   (out_state[c]),
            .busy_o  (busy[c]),
            .done_o  (complete[c])
        );
    end

    // channels never armed since the last clear must not hold all_complete low
    always_ff @(posedge clk) begin
        if (!rst || hard_stop) mask_q <= '0;
        else mask_q <= mask_q | arm;
    end

    assign all_complete = (|mask_q) && (&(complete | ~mask_q));

endmodule

// File: tb/tb_io_pulse_seq_ctrl.sv
// tb_io_pulse_seq_ctrl: scoreboard bench for io_pulse_seq_ctrl with an edge-indexed timing model.
module tb_io_pulse_seq_ctrl;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int CW  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH-1:0]    rest_level = '0;
    logic [NCH-1:0]    arm = '0;
    logic              go = 1'b0;
    logic              hard_stop = 1'b0;
    logic [NCH*DW-1:0] cfg_delay = '0;
    logic [NCH*DW-1:0] cfg_width = '0;
    logic [NCH*DW-1:0] cfg_gap = '0;
    logic [NCH*CW-1:0] cfg_count = '0;
    logic [NCH-1:0]    out_state, busy, complete;
    logic              all_complete;

    always #5 clk = ~clk;

    io_pulse_seq_ctrl #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rest_level   (rest_level),
        .arm          (arm),
        .go           (go),
        .hard_stop    (hard_stop),
        .cfg_delay    (cfg_delay),
        .cfg_width    (cfg_width),
        .cfg_gap      (cfg_gap),
        .cfg_count    (cfg_count),
        .out_state    (out_state),
        .busy         (busy),
        .complete     (complete),
        .all_complete (all_complete)
    );

    typedef struct {
        int             cyc;
        logic [NCH-1:0] o, b, c;
        logic           a;
    } exp_t;

    typedef enum {M_IDLE, M_ARMED, M_RUN, M_DONE} mst_e;

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    mst_e   ms[NCH];
    longint md[NCH], mw[NCH], mg[NCH], mn[NCH], e0[NCH];
    bit     mdone[NCH], mmask[NCH];

    // edge at which complete rises, counted from the trigger edge
    function automatic longint tdone(int c);
        return (mw[c] == 0 || mn[c] == 0) ? md[c] + 1 : md[c] + 1 + mn[c] * mw[c] + (mn[c] - 1) * mg[c];
    endfunction

    // pulse k occupies [D+1+k(W+G), D+1+k(W+G)+W) edges after the trigger
    function automatic bit active(int c);
        longint t, u, p;
        if (ms[c] != M_RUN) return 0;
        t = longint'(cyc) - e0[c];
        if (t < md[c] + 1) return 0;
        u = t - md[c] - 1;
        p = mw[c] + mg[c];
        if (p == 0) return 0;
        return (u / p) < mn[c] && (u % p) < mw[c];
    endfunction

    task automatic model_edge();
        exp_t e;
        bit   all_ok, any;
        cyc++;
        all_ok = 1;
        any    = 0;
        for (int c = 0; c < NCH; c++) begin
            mst_e p;
            p = ms[c];
            if (!rst || hard_stop) begin
                ms[c]    = M_IDLE;
                mdone[c] = 0;
                mmask[c] = 0;
            end else begin
                if (arm[c]) mmask[c] = 1;
                if (p == M_RUN) begin
                    if (longint'(cyc) - e0[c] >= tdone(c)) begin
                        ms[c]    = M_DONE;
                        mdone[c] = 1;
                    end
                end else if (arm[c]) begin
                    md[c]    = longint'(cfg_delay[c*DW +: DW]);
                    mw[c]    = longint'(cfg_width[c*DW +: DW]);
                    mg[c]    = longint'(cfg_gap[c*DW +: DW]);
                    mn[c]    = longint'(cfg_count[c*CW +: CW]);
                    mdone[c] = 0;
                    ms[c]    = M_ARMED;
                    if (go && p != M_DONE) begin
                        ms[c] = M_RUN;
                        e0[c] = cyc;
                    end
                end else if (go && p == M_ARMED) begin
                    ms[c] = M_RUN;
                    e0[c] = cyc;
                end
            end
            e.o[c] = rest_level[c] ^ active(c);
            e.b[c] = ms[c] == M_RUN;
            e.c[c] = mdone[c];
            if (mmask[c]) begin
                any = 1;
                if (!mdone[c]) all_ok = 0;
            end
        end
        e.a   = any && all_ok;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #2;
        end
    endtask

    task automatic setc(int c, int d, int w, int g, int n);
        cfg_delay[c*DW +: DW] = DW'(d);
        cfg_width[c*DW +: DW] = DW'(w);
        cfg_gap[c*DW +: DW]   = DW'(g);
        cfg_count[c*CW +: CW] = CW'(n);
    endtask

    task automatic pulse_arm(logic [NCH-1:0] a, logic g);
        arm = a;
        go  = g;
        tick();
        arm = '0;
        go  = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks += 4;
                if (out_state !== e.o) begin
                    errors++;
                    $display("FAIL cyc=%0d out_state got=%b exp=%b", e.cyc, out_state, e.o);
                end
                if (busy !== e.b) begin
                    errors++;
                    $display("FAIL cyc=%0d busy got=%b exp=%b", e.cyc, busy, e.b);
                end
                if (complete !== e.c) begin
                    errors++;
                    $display("FAIL cyc=%0d complete got=%b exp=%b", e.cyc, complete, e.c);
                end
                if (all_complete !== e.a) begin
                    errors++;
                    $display("FAIL cyc=%0d all_complete got=%b exp=%b", e.cyc, all_complete, e.a);
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < NCH; c++) begin
            ms[c] = M_IDLE; md[c] = 0; mw[c] = 0; mg[c] = 0; mn[c] = 0; e0[c] = 0;
            mdone[c] = 0; mmask[c] = 0;
        end
        #2;
        tick(3);
        rst = 1'b1;
        tick(2);
        // channel 0: single 5-cycle pulse after 3-cycle delay
        setc(0, 3, 5, 0, 1);
        pulse_arm(4'b0001, 1'b0);
        tick();
        pulse_arm(4'b0000, 1'b1);
        tick(12);
        // channel 1: three 2-cycle pulses, rest high, arm and go together
        rest_level = 4'b0010;
        setc(1, 0, 2, 3, 3);
        pulse_arm(4'b0010, 1'b1);
        tick(16);
        // trigger with nothing armed
        pulse_arm(4'b0000, 1'b1);
        tick(3);
        // several channels, channel 2 left unarmed, re-trigger and re-arm mid-run
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rest_level = 4'b1000;
        setc(0, 1, 2, 1, 2);
        setc(1, 7, 2, 1, 2);
        setc(3, 4, 3, 2, 2);
        pulse_arm(4'b1011, 1'b0);
        pulse_arm(4'b0000, 1'b1);
        setc(1, 0, 9, 0, 5);
        tick(2);
        pulse_arm(4'b0010, 1'b1);
        tick(20);
        // degenerate configs
        rst = 1'b0;
        tick();
        rst = 1'b1;
        setc(0, 2, 0, 1, 2);
        setc(1, 2, 3, 1, 0);
        setc(2, 1, 2, 0, 4);
        pulse_arm(4'b0111, 1'b1);
        tick(14);
        // hard_stop mid-pulse, arm held while stopped, then restart
        setc(0, 1, 6, 0, 1);
        pulse_arm(4'b0001, 1'b1);
        tick(4);
        hard_stop = 1'b1;
        pulse_arm(4'b0001, 1'b1);
        tick();
        hard_stop = 1'b0;
        pulse_arm(4'b0001, 1'b1);
        tick(12);
        // reset mid-gap, then restart
        setc(1, 0, 2, 5, 3);
        pulse_arm(4'b0010, 1'b1);
        tick(4);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        pulse_arm(4'b0010, 1'b1);
        tick(22);
        // randomized traffic; config buses keep changing so late edits must be ignored
        for (int i = 0; i < 3000; i++) begin
            rst       = $urandom_range(0, 199) != 0;
            hard_stop = $urandom_range(0, 149) == 0;
            go        = $urandom_range(0, 9) == 0;
            for (int c = 0; c < NCH; c++) begin
                arm[c] = $urandom_range(0, 14) == 0;
                if ($urandom_range(0, 3) == 0)
                    setc(c, $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4));
            end
            if ($urandom_range(0, 29) == 0) rest_level = NCH'($urandom);
            tick();
        end
        arm = '0;
        go  = 1'b0;
        tick(2);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
